// File: rtl/mlp_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mlp_layer_sequencer
// Description : Steps each test vector through NUM_LAYERS MLP layers, strobes
//               hidden-layer neuron registers and emits results via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int NEURONS    = 10,
    parameter int NUM_CASES  = 750,
    parameter int ADDR_W     = 10,
    parameter int LAYER_W    = $clog2(NUM_LAYERS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              mac_done,
    input  logic                              out_ready,
    output logic [LAYER_W-1:0]                curr_layer,
    output logic [(NUM_LAYERS-1)*NEURONS-1:0] ld_en,
    output logic [ADDR_W-1:0]                 addr,
    output logic                              inc_addr,
    output logic                              result_valid,
    output logic                              busy,
    output logic                              init,
    output logic                              done
);

    localparam int                 c_LD_W       = (NUM_LAYERS-1)*NEURONS;
    localparam logic [LAYER_W-1:0] c_LAST_LAYER = LAYER_W'(NUM_LAYERS-1);
    localparam logic [ADDR_W-1:0]  c_LAST_ADDR  = ADDR_W'(NUM_CASES-1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LAYER = 3'd1,
        S_LOAD  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LAYER_W-1:0]  r_layer;
    logic [LAYER_W-1:0]  w_layer_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [LAYER_W-1:0]  w_curr_layer_nxt;
    logic [c_LD_W-1:0]   w_ld_en_nxt;

    // Only the address handshake is Mealy; everything else is registered.
    assign inc_addr = (r_state == S_EMIT) && out_ready && !abort;
    assign addr     = r_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_layer_nxt = r_layer;
        w_addr_nxt  = r_addr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LAYER;
                    w_layer_nxt = '0;
                    w_addr_nxt  = '0;
                end
            end
            S_LAYER: begin
                if (mac_done) begin
                    w_state_nxt = (r_layer < c_LAST_LAYER) ? S_LOAD : S_EMIT;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_LAYER;
                w_layer_nxt = r_layer + LAYER_W'(1);
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (r_addr == c_LAST_ADDR) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_LAYER;
                        w_layer_nxt = '0;
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort freezes the counters so the failing vector stays visible.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_layer_nxt = r_layer;
            w_addr_nxt  = r_addr;
        end
    end

    always_comb begin
        w_curr_layer_nxt = '0;
        case (w_state_nxt)
            S_LAYER, S_LOAD: w_curr_layer_nxt = w_layer_nxt;
            S_EMIT:          w_curr_layer_nxt = c_LAST_LAYER;
            default:         w_curr_layer_nxt = '0;
        endcase
    end

    for (genvar k = 0; k < NUM_LAYERS-1; k++) begin : g_ld_en
        assign w_ld_en_nxt[k*NEURONS +: NEURONS] =
            {NEURONS{(w_state_nxt == S_LOAD) && (w_layer_nxt == LAYER_W'(k))}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_layer      <= '0;
            r_addr       <= '0;
            curr_layer   <= '0;
            ld_en        <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            init         <= 1'b1;
            done         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_layer      <= w_layer_nxt;
            r_addr       <= w_addr_nxt;
            curr_layer   <= w_curr_layer_nxt;
            ld_en        <= w_ld_en_nxt;
            result_valid <= (w_state_nxt == S_EMIT);
            busy         <= (w_state_nxt != S_IDLE);
            init         <= (w_state_nxt == S_IDLE);
            done         <= (w_state_nxt == S_DONE);
        end
    end

endmodule
`default_nettype wire
